// File: rtl/register_write_arbiter.sv
// Round-robin req/grant/ack arbiter sharing one WIDTH-bit write-enabled register among N writers.
// Define ARB_LOCK_EN to add the lock port, which lets the current owner keep the grant.

module register_write_arbiter_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end
endmodule

module register_write_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]       lock,
`endif
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_ACK} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    logic [N-1:0]     elig_c;
    logic             found_c;
    logic [PW-1:0]    pick_c;
    logic [PW-1:0]    pick_nxt_c;
    logic [WIDTH-1:0] pick_data_c;
    logic             keep_c;
    logic [WIDTH-1:0] keep_data_c;
    logic             wr_c;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return PW'(s);
    endfunction

    // Round-robin search from ptr; the owner's own req is masked while it is being acked.
    always_comb begin
        elig_c = req;
        if (state_q == ST_ACK) begin
            elig_c = req & ~grant_q;
        end
        found_c = 1'b0;
        pick_c  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_c && elig_c[rr_idx(ptr_q, k)]) begin
                found_c = 1'b1;
                pick_c  = rr_idx(ptr_q, k);
            end
        end
        pick_nxt_c = (pick_c == PW'(N - 1)) ? '0 : PW'(pick_c + PW'(1));
        pick_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(pick_c) == i) begin
                pick_data_c = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_LOCK_EN
    // Owner holding lock with req still high is regranted without masking or pointer advance.
    assign keep_c = (state_q == ST_ACK) && |(grant_q & lock & req);
    always_comb begin
        keep_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                keep_data_c = wdata[i*WIDTH +: WIDTH];
            end
        end
    end
`else
    assign keep_c      = 1'b0;
    assign keep_data_c = hold_q;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE, ST_ACK: begin
                if (keep_c) begin
                    state_d = ST_WRITE;
                    hold_d  = keep_data_c;
                end else if (found_c) begin
                    state_d = ST_WRITE;
                    grant_d = N'(1) << pick_c;
                    hold_d  = pick_data_c;
                    ptr_d   = pick_nxt_c;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
                ack_d   = grant_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign wr_c = (state_q == ST_WRITE);

    register_write_arbiter_reg #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .rst (~reset),
        .we  (wr_c),
        .d   (hold_q),
        .q   (q)
    );

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule
